// File: rtl/letc_core_pkg.sv
// Shared LETC core types and constants used by the fetch pipeline.
package letc_core_pkg;

    typedef logic [31:0] pc_t;

    localparam pc_t INSTR_BYTES = 32'd4;

    typedef enum logic [0:0] {
        F1_RUN  = 1'b0,
        F1_HALT = 1'b1
    } f1_state_e;

    typedef struct packed {
        pc_t  pc;
        logic misaligned;
    } f1_to_f2_s;

endpackage : letc_core_pkg

// File: rtl/letc_core_imss_if.sv
// Instruction-fetch request channel between F1 and the instruction memory subsystem.
interface letc_core_imss_if;
    import letc_core_pkg::*;

    logic req_valid;
    pc_t  req_addr;
    logic req_ready;

    modport fetch1 (
        output req_valid,
        output req_addr,
        input  req_ready
    );

    modport imss (
        input  req_valid,
        input  req_addr,
        output req_ready
    );

endinterface : letc_core_imss_if

// File: rtl/letc_core_f1_redirect_hold.sv
// Holds a redirect that arrives while F1 is stalled and merges it with any live redirect.
module letc_core_f1_redirect_hold
    import letc_core_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic redirect_valid,
    input  pc_t  redirect_pc,
    output logic eff_redir,
    output pc_t  eff_pc
);

    logic pend_valid_q, pend_valid_d;
    pc_t  pend_pc_q, pend_pc_d;

    // A live redirect takes precedence over the held one; a stalled redirect overwrites older ones.
    always_comb begin
        eff_redir    = redirect_valid | pend_valid_q;
        eff_pc       = redirect_valid ? redirect_pc : pend_pc_q;
        pend_valid_d = stall ? (pend_valid_q | redirect_valid) : 1'b0;
        pend_pc_d    = (stall & redirect_valid) ? redirect_pc : pend_pc_q;
    end

    // Pending redirect register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

endmodule : letc_core_f1_redirect_hold

// File: rtl/letc_core_stage_fetch1.sv
// LETC fetch stage 1: owns the fetch PC, issues IMSS requests and produces the F1->F2 payload.
module letc_core_stage_fetch1
    import letc_core_pkg::*;
#(
    parameter pc_t RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f1_flush,
    input  logic              f1_stall,
    input  logic              f2_ready,
    input  logic              redirect_valid,
    input  pc_t               redirect_pc,
    letc_core_imss_if.fetch1  imss_if,
    output logic              f1_to_f2_valid,
    output f1_to_f2_s         f1_to_f2
);

    pc_t       pc_q, pc_d;
    f1_state_e state_q, state_d;
    logic      eff_redir;
    pc_t       eff_pc;
    logic      misaligned;
    logic      req_valid;
    logic      fire;
    logic      mis_emit;

    letc_core_f1_redirect_hold u_redirect_hold (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (f1_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .eff_redir      (eff_redir),
        .eff_pc         (eff_pc)
    );

    // Request/emit decode; outputs are forced low while reset is asserted.
    always_comb begin
        misaligned = (pc_q[1:0] != 2'b00);
        req_valid  = rst_n & (state_q == F1_RUN) & ~f1_flush & ~eff_redir & f2_ready & ~misaligned;
        fire       = req_valid & imss_if.req_ready & ~f1_stall;
        mis_emit   = rst_n & (state_q == F1_RUN) & misaligned & f2_ready
                   & ~f1_flush & ~f1_stall & ~eff_redir;
    end

    assign imss_if.req_valid   = req_valid;
    assign imss_if.req_addr    = pc_q;
    assign f1_to_f2_valid      = fire | mis_emit;
    assign f1_to_f2.pc         = pc_q;
    assign f1_to_f2.misaligned = misaligned;

    // Next PC/state: stall holds, redirect reloads, fire advances, misaligned emit halts.
    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        if (f1_stall) begin
            pc_d    = pc_q;
            state_d = state_q;
        end else if (eff_redir) begin
            pc_d    = eff_pc;
            state_d = F1_RUN;
        end else if (fire) begin
            pc_d    = pc_q + INSTR_BYTES;
        end else if (mis_emit) begin
            state_d = F1_HALT;
        end
    end

    // Architectural fetch PC and run/halt state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            state_q <= F1_RUN;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
        end
    end

    a_no_x_ctrl: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({req_valid, f1_to_f2_valid, state_q, f1_flush, f1_stall, f2_ready, redirect_valid}));

    a_flush_stall_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(f1_flush && f1_stall));

    a_no_valid_in_halt: assert property (@(posedge clk) disable iff (!rst_n)
        !(f1_to_f2_valid && (state_q == F1_HALT)));

    a_req_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (req_valid && !imss_if.req_ready) |=> $stable(imss_if.req_addr));

endmodule : letc_core_stage_fetch1

// File: tb/tb_letc_core_stage_fetch1.sv
// Directed, table-driven bench for the LETC fetch stage 1.
module tb_letc_core_stage_fetch1;
    import letc_core_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      f1_flush;
    logic      f1_stall;
    logic      f2_ready;
    logic      redirect_valid;
    pc_t       redirect_pc;
    logic      f1_to_f2_valid;
    f1_to_f2_s f1_to_f2;

    letc_core_imss_if imss_if ();

    letc_core_stage_fetch1 #(.RESET_PC(32'h0000_1000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .f1_flush       (f1_flush),
        .f1_stall       (f1_stall),
        .f2_ready       (f2_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imss_if        (imss_if),
        .f1_to_f2_valid (f1_to_f2_valid),
        .f1_to_f2       (f1_to_f2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic flush;
        logic stall;
        logic f2r;
        logic rv;
        pc_t  rpc;
        logic rr;
        logic e_req;
        pc_t  e_pc;
        logic e_f1v;
        logic e_mis;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // flush, stall, f2_ready, redirect_valid, redirect_pc, req_ready -> req_valid, pc, f1v, misaligned
    task automatic add(input logic fl, input logic st, input logic f2r, input logic rv, input pc_t rpc,
                       input logic rr, input logic e_req, input pc_t e_pc, input logic e_f1v,
                       input logic e_mis);
        vec_t v;
        v.flush = fl; v.stall = st; v.f2r = f2r; v.rv = rv; v.rpc = rpc; v.rr = rr;
        v.e_req = e_req; v.e_pc = e_pc; v.e_f1v = e_f1v; v.e_mis = e_mis;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic fl, input logic st, input logic f2r, input logic rv,
                         input pc_t rpc, input logic rr);
        f1_flush = fl; f1_stall = st; f2_ready = f2r;
        redirect_valid = rv; redirect_pc = rpc; imss_if.req_ready = rr;
    endtask

    task automatic check_outputs(input string tag, input logic e_req, input pc_t e_pc,
                                 input logic e_f1v, input logic e_mis);
        chk({tag, ".req_valid"}, 32'(imss_if.req_valid), 32'(e_req));
        chk({tag, ".req_addr"}, imss_if.req_addr, e_pc);
        chk({tag, ".f1v"}, 32'(f1_to_f2_valid), 32'(e_f1v));
        chk({tag, ".f1pc"}, f1_to_f2.pc, e_pc);
        chk({tag, ".mis"}, 32'(f1_to_f2.misaligned), 32'(e_mis));
    endtask

    initial begin
        // Sequential fetch from reset
        add(0,0,1,0,0,1, 1,32'h1000,1,0);
        add(0,0,1,0,0,1, 1,32'h1004,1,0);
        add(0,0,1,0,0,1, 1,32'h1008,1,0);
        // Live redirect: bubble then target
        add(0,0,1,1,32'h2000,1, 0,32'h100C,0,0);
        add(0,0,1,0,0,1, 1,32'h2000,1,0);
        add(0,0,1,0,0,1, 1,32'h2004,1,0);
        // Redirects during a 3-cycle stall; newest wins
        add(0,1,1,1,32'h3000,1, 0,32'h2008,0,0);
        add(0,1,1,0,0,1, 0,32'h2008,0,0);
        add(0,1,1,1,32'h4000,1, 0,32'h2008,0,0);
        add(0,0,1,0,0,1, 0,32'h2008,0,0);
        add(0,0,1,0,0,1, 1,32'h4000,1,0);
        // IMSS back-pressure at 1008
        add(0,0,1,1,32'h1008,1, 0,32'h4004,0,0);
        add(0,0,1,0,0,0, 1,32'h1008,0,0);
        add(0,0,1,0,0,0, 1,32'h1008,0,0);
        add(0,0,1,0,0,1, 1,32'h1008,1,0);
        add(0,0,1,0,0,1, 1,32'h100C,1,0);
        // Flush drops output, same PC re-requested
        add(1,0,1,0,0,1, 0,32'h1010,0,0);
        add(0,0,1,0,0,1, 1,32'h1010,1,0);
        // F2 not ready
        add(0,0,0,0,0,1, 0,32'h1014,0,0);
        // Misaligned target: one emit then HALT until redirect
        add(0,0,1,1,32'h5002,1, 0,32'h1014,0,0);
        add(0,0,1,0,0,1, 0,32'h5002,1,1);
        add(0,0,1,0,0,1, 0,32'h5002,0,1);
        add(0,0,1,0,0,1, 0,32'h5002,0,1);
        add(0,0,1,1,32'h0100,1, 0,32'h5002,0,1);
        add(0,0,1,0,0,1, 1,32'h0100,1,0);
        // Wrap-around
        add(0,0,1,1,32'hFFFF_FFFC,1, 0,32'h0104,0,0);
        add(0,0,1,0,0,1, 1,32'hFFFF_FFFC,1,0);
        add(0,0,1,0,0,1, 1,32'h0000_0000,1,0);
        add(0,0,1,0,0,1, 1,32'h0000_0004,1,0);
        // Redirect together with flush
        add(1,0,1,1,32'h0600,1, 0,32'h0008,0,0);
        add(0,0,1,0,0,1, 1,32'h0600,1,0);
        add(0,0,1,0,0,1, 1,32'h0604,1,0);

        rst_n = 1'b0;
        drive(0,0,1,0,0,1);
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs("reset", 1'b0, 32'h1000, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].flush, vecs[i].stall, vecs[i].f2r, vecs[i].rv, vecs[i].rpc, vecs[i].rr);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_pc,
                          vecs[i].e_f1v, vecs[i].e_mis);
            @(posedge clk);
            #1;
        end

        // Stall while misaligned: no emit, and HALT is not entered
        drive(0,0,1,1,32'h0702,1);
        #1;
        @(posedge clk);
        #1;
        drive(0,1,1,0,0,1);
        #1;
        check_outputs("mis_stall", 1'b0, 32'h0702, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        drive(0,0,1,0,0,1);
        #1;
        check_outputs("mis_after_stall", 1'b0, 32'h0702, 1'b1, 1'b1);
        @(posedge clk);
        #1;
        drive(0,0,1,1,32'h0800,1);
        @(posedge clk);
        #1;
        drive(0,0,1,0,0,1);
        #1;
        check_outputs("run_0800", 1'b1, 32'h0800, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        // Asynchronous reset mid-stream
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 32'h1000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check_outputs("post_rst0", 1'b1, 32'h1000, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("post_rst1", 1'b1, 32'h1004, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule : tb_letc_core_stage_fetch1
